// File: rtl/pipeline_scoreboard_pkg.sv
// Shared core definitions for the multi-cycle unit scoreboard: unit encodings and default sizes.
// Pure declarations; no logic, latency or flow control lives here.
package pipeline_scoreboard_pkg;

  localparam int NUNITS_DEF   = 3;
  localparam int NSRC_DEF     = 3;
  localparam int RW_DEF       = 5;
  localparam int ZERO_REG_DEF = 1;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic [1:0] {
    UNIT_MUL    = 2'd0,
    UNIT_ATOMIC = 2'd1,
    UNIT_FPU    = 2'd2
  } unit_e;

endpackage

// File: rtl/scoreboard_entry.sv
// One unit's in-flight entry plus its one-cycle writeback shadow, with per-port rd comparators.
// State updates at the next edge; raw_hit/busy are combinational from registered state.
module scoreboard_entry
  import pipeline_scoreboard_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int RW   = RW_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             issue,
  input  logic             issue_wr,
  input  logic [RW-1:0]    issue_rd,
  input  logic             done,
  input  logic [NSRC*RW-1:0] src,
  input  logic [NSRC-1:0]  src_chk,
  output logic             busy,
  output logic             raw_hit
);

  typedef struct packed {
    logic          valid;
    logic          wr;
    logic [RW-1:0] rd;
  } slot_t;

  slot_t entry_q, entry_d, shadow_q, shadow_d;
  logic [NSRC-1:0] hit;

  always_comb begin
    entry_d  = entry_q;
    shadow_d = '0;
    if (flush) begin
      entry_d = '0;
    end else begin
      // The shadow keeps the register blocked for the cycle the result is being written back.
      if (done && entry_q.valid) begin
        entry_d.valid = 1'b0;
        shadow_d      = '{valid: 1'b1, wr: entry_q.wr, rd: entry_q.rd};
      end
      if (issue) begin
        entry_d = '{valid: 1'b1, wr: issue_wr, rd: issue_rd};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_q  <= '0;
      shadow_q <= '0;
    end else begin
      entry_q  <= entry_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    hit = '0;
    for (int k = 0; k < NSRC; k++) begin
      hit[k] = src_chk[k] &
               ((entry_q.valid  & entry_q.wr  & (src[k*RW +: RW] == entry_q.rd)) |
                (shadow_q.valid & shadow_q.wr & (src[k*RW +: RW] == shadow_q.rd)));
    end
  end

  assign raw_hit = |hit;
  assign busy    = entry_q.valid;

endmodule

// File: rtl/pipeline_scoreboard.sv
// ID-stage hazard scoreboard for multi-cycle units: combinational stall/bubble from registered entries.
// Issue is recorded at the next edge; a held instruction simply waits while stall is high.
module pipeline_scoreboard
  import pipeline_scoreboard_pkg::*;
#(
  parameter int NUNITS   = NUNITS_DEF,
  parameter int NSRC     = NSRC_DEF,
  parameter int RW       = RW_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  localparam int UW      = (NUNITS > 1) ? $clog2(NUNITS) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               id_valid,
  input  logic [NSRC*RW-1:0] id_src,
  input  logic [NSRC-1:0]    id_src_en,
  input  logic               id_long,
  input  logic [UW-1:0]      id_unit,
  input  logic [RW-1:0]      id_rd,
  input  logic               id_rd_we,
  input  logic [NUNITS-1:0]  unit_done,
  input  logic               flush,
  output logic               stall,
  output logic               bubble,
  output logic [NUNITS-1:0]  unit_busy,
  output logic [CNT_W-1:0]   stall_count
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [NSRC-1:0]   src_chk;
  logic [NUNITS-1:0] raw_vec;
  logic [NUNITS-1:0] busy_vec;
  logic              struct_hz;
  logic              issue;
  logic              issue_wr;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  always_comb begin
    src_chk = '0;
    for (int k = 0; k < NSRC; k++) begin
      src_chk[k] = id_valid & id_src_en[k] & ~(ZR && (id_src[k*RW +: RW] == '0));
    end
  end

  // A unit finishing this cycle still counts as occupied; the new issue goes in one cycle later.
  always_comb begin
    struct_hz = 1'b0;
    for (int u = 0; u < NUNITS; u++) begin
      if (id_unit == UW'(u)) struct_hz = busy_vec[u];
    end
    struct_hz = struct_hz & id_valid & id_long;
  end

  assign stall    = (|raw_vec) | struct_hz;
  assign bubble   = stall & id_valid;
  assign issue    = id_valid & id_long & ~stall & ~flush;
  assign issue_wr = id_rd_we & ~(ZR && (id_rd == '0));

  for (genvar u = 0; u < NUNITS; u++) begin : g_unit
    scoreboard_entry #(
      .NSRC (NSRC),
      .RW   (RW)
    ) u_entry (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .issue    (issue && (id_unit == UW'(u))),
      .issue_wr (issue_wr),
      .issue_rd (id_rd),
      .done     (unit_done[u]),
      .src      (id_src),
      .src_chk  (src_chk),
      .busy     (busy_vec[u]),
      .raw_hit  (raw_vec[u])
    );
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_count_q <= '0;
    else          stall_count_q <= stall_count_d;
  end

  assign unit_busy   = busy_vec;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Bench: two scoreboards (integer file with 4-bit counter, FP file with 16-bit counter) on shared stimulus.
// Expected values come from a register-set model of pending and just-retired writes.
module tb_pipeline_scoreboard;
  import pipeline_scoreboard_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, id_valid, id_long, id_rd_we, flush;
  logic [14:0] id_src;
  logic [2:0]  id_src_en, unit_done;
  logic [1:0]  id_unit;
  logic [4:0]  id_rd;
  logic        stall0, bubble0, stall1, bubble1;
  logic [2:0]  busy0, busy1;
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  int tests = 0;
  int fails = 0;

  // Model: per config, which units hold a pending write (rd or -1), and the set of registers retired last cycle.
  bit          m_busy [2][3];
  int          m_rd   [2][3];
  bit [31:0]   m_recent [2];
  int unsigned m_cnt  [2];

  pipeline_scoreboard #(.ZERO_REG(1), .CNT_W(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_src(id_src), .id_src_en(id_src_en),
    .id_long(id_long), .id_unit(id_unit), .id_rd(id_rd), .id_rd_we(id_rd_we), .unit_done(unit_done),
    .flush(flush), .stall(stall0), .bubble(bubble0), .unit_busy(busy0), .stall_count(cnt0));

  pipeline_scoreboard #(.ZERO_REG(0), .CNT_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_src(id_src), .id_src_en(id_src_en),
    .id_long(id_long), .id_unit(id_unit), .id_rd(id_rd), .id_rd_we(id_rd_we), .unit_done(unit_done),
    .flush(flush), .stall(stall1), .bubble(bubble1), .unit_busy(busy1), .stall_count(cnt1));

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  function automatic bit m_stall(input int c);
    bit zr = (c == 0);
    bit hz = 1'b0;
    if (!id_valid) return 1'b0;
    for (int k = 0; k < 3; k++) begin
      int s = int'(id_src[k*5 +: 5]);
      if (id_src_en[k] && !(zr && s == 0)) begin
        for (int u = 0; u < 3; u++) if (m_busy[c][u] && m_rd[c][u] == s) hz = 1'b1;
        if (m_recent[c][s]) hz = 1'b1;
      end
    end
    if (id_long && id_unit < 2'd3 && m_busy[c][id_unit]) hz = 1'b1;
    return hz;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int u = 0; u < 3; u++) begin
        m_busy[c][u] = 1'b0;
        m_rd[c][u]   = -1;
      end
      m_recent[c] = '0;
      m_cnt[c]    = 0;
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < 2; c++) begin
      bit          zr  = (c == 0);
      bit          st  = m_stall(c);
      int unsigned top = (c == 0) ? 15 : 65535;
      bit [31:0]   nr  = '0;
      if (!reset_n) continue;
      if (st && m_cnt[c] < top) m_cnt[c]++;
      if (flush) begin
        for (int u = 0; u < 3; u++) m_busy[c][u] = 1'b0;
        m_recent[c] = '0;
      end else begin
        for (int u = 0; u < 3; u++) begin
          if (unit_done[u] && m_busy[c][u]) begin
            m_busy[c][u] = 1'b0;
            if (m_rd[c][u] >= 0) nr[m_rd[c][u]] = 1'b1;
          end
        end
        if (id_valid && id_long && !st && id_unit < 2'd3) begin
          m_busy[c][id_unit] = 1'b1;
          m_rd[c][id_unit]   = (id_rd_we && !(zr && id_rd == 5'd0)) ? int'(id_rd) : -1;
        end
        m_recent[c] = nr;
      end
    end
    if (!reset_n) model_reset();
  endtask

  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      bit       es = m_stall(c);
      bit [2:0] eb = {m_busy[c][2], m_busy[c][1], m_busy[c][0]};
      chk("stall",     c, (c == 0) ? 32'(stall0)  : 32'(stall1),  32'(es));
      chk("bubble",    c, (c == 0) ? 32'(bubble0) : 32'(bubble1), 32'(es & id_valid));
      chk("unit_busy", c, (c == 0) ? 32'(busy0)   : 32'(busy1),   32'(eb));
      chk("count",     c, (c == 0) ? 32'(cnt0)    : 32'(cnt1),    m_cnt[c]);
    end
  endtask

  task automatic cyc();
    #4;
    check_all();
  endtask

  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cyc();
    adv();
  endtask

  task automatic idle();
    id_valid = 0; id_src = '0; id_src_en = '0; id_long = 0; id_unit = '0;
    id_rd = '0; id_rd_we = 0; unit_done = '0; flush = 0;
  endtask

  task automatic set_issue(input int u, input int rd);
    idle();
    id_valid = 1; id_long = 1; id_unit = 2'(u); id_rd = 5'(rd); id_rd_we = 1;
  endtask

  task automatic set_read(input int s0, input int s1, input int s2, input logic [2:0] en);
    idle();
    id_valid = 1; id_src = {5'(s2), 5'(s1), 5'(s0)}; id_src_en = en;
  endtask

  initial begin
    reset_n = 0;
    idle();
    model_reset();
    @(posedge clk); #1;
    step();
    reset_n = 1;

    // RAW on a multiply result: entry, done cycle, shadow cycle, then free.
    set_issue(int'(UNIT_MUL), 5); step();
    set_read(5, 0, 0, 3'b001);
    cyc(); chk("mul_raw", 0, 32'(stall0), 1); adv();
    step();
    unit_done = 3'b001;
    cyc(); chk("mul_done_cycle", 0, 32'(stall0), 1); adv();
    unit_done = 3'b000;
    cyc(); chk("mul_shadow", 0, 32'(stall0), 1); adv();
    cyc(); chk("mul_free", 0, 32'(stall0), 0); adv();

    // Register 0: hardwired zero on the integer file, ordinary on the FP file.
    set_issue(int'(UNIT_MUL), 0); step();
    set_read(0, 0, 0, 3'b001);
    cyc(); chk("x0_int", 0, 32'(stall0), 0); chk("f0_fp", 1, 32'(stall1), 1); adv();
    step();
    unit_done = 3'b001; step();
    unit_done = 3'b000;
    cyc(); chk("f0_shadow", 1, 32'(stall1), 1); adv();
    step();

    // Structural hazard on the atomic unit.
    set_issue(int'(UNIT_ATOMIC), 10); step();
    set_issue(int'(UNIT_ATOMIC), 11);
    step(); step();
    unit_done = 3'b010;
    cyc(); chk("struct_done_cycle", 0, 32'(stall0), 1); adv();
    unit_done = 3'b000;
    cyc(); chk("struct_release", 0, 32'(stall0), 0); adv();
    idle();
    cyc(); chk("struct_accepted", 0, 32'(busy0), 32'(3'b010)); adv();
    unit_done = 3'b010; step();
    idle(); step(); step();

    // Two pending units, read hits only the FPU one.
    set_issue(int'(UNIT_MUL), 3); step();
    set_issue(int'(UNIT_FPU), 7); step();
    set_read(7, 9, 0, 3'b011);
    cyc(); chk("two_pending", 0, 32'(stall0), 1); adv();
    unit_done = 3'b100; step();
    unit_done = 3'b000;
    cyc(); chk("fpu_shadow", 0, 32'(stall0), 1); adv();
    cyc(); chk("fpu_free", 0, 32'(stall0), 0); adv();
    idle(); unit_done = 3'b001; step();
    idle(); step(); step();

    // Flush beats issue; flush clears everything pending.
    set_issue(int'(UNIT_MUL), 4); flush = 1; step();
    idle();
    cyc(); chk("flush_vs_issue", 0, 32'(busy0), 0); adv();
    set_issue(int'(UNIT_MUL), 4); step();
    set_issue(int'(UNIT_ATOMIC), 6); step();
    idle(); flush = 1;
    cyc(); chk("pre_flush_busy", 0, 32'(busy0), 32'(3'b011)); adv();
    flush = 0;
    cyc(); chk("post_flush_busy", 0, 32'(busy0), 0); chk("post_flush_busy", 1, 32'(busy1), 0); adv();

    // Counter saturation, then an asynchronous reset mid-stall.
    reset_n = 0; model_reset(); #1;
    step(); step();
    reset_n = 1;
    set_issue(int'(UNIT_FPU), 8); step();
    set_read(8, 0, 0, 3'b001);
    for (int i = 0; i < 20; i++) step();
    cyc();
    chk("count_sat", 0, 32'(cnt0), 15);
    chk("count_wide", 1, 32'(cnt1), 20);
    #1;
    reset_n = 0; model_reset();
    #1;
    chk("async_stall", 0, 32'(stall0), 0);
    chk("async_count", 0, 32'(cnt0), 0);
    chk("async_busy", 0, 32'(busy0), 0);
    chk("async_count", 1, 32'(cnt1), 0);
    @(posedge clk); #1;
    idle(); step();
    reset_n = 1;
    step();

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      id_valid  = ($urandom_range(0, 3) != 0);
      id_src    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_src_en = 3'($urandom_range(0, 7));
      id_long   = ($urandom_range(0, 2) == 0);
      id_unit   = 2'($urandom_range(0, 2));
      id_rd     = 5'($urandom_range(0, 7));
      id_rd_we  = ($urandom_range(0, 3) != 0);
      unit_done = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
